alu_txn_driver: RTL and testbench
=================================

ALU_TXN_DRIVER -- requirements
Module: alu_txn_driver

Interface
REQ-001 SHALL have parameters: M, 32, operand/result width; RSP_DEPTH, 4, response FIFO entries (power of 2, >=2).
REQ-002 SHALL have ports (name  direction  width  meaning): clk  in  1  single clock, all state on rising edge.
REQ-003 i_reset  in  1  reset, asynchronous, active-low.
REQ-004 i_cmd_valid  in  1  command offered; o_cmd_ready  out  1  command accepted when both high at an edge.
REQ-005 i_cmd_A, i_cmd_B  in  M  operands; i_cmd_op  in  4  operation code.
REQ-006 o_alu_A, o_alu_B  out  M; o_alu_op  out  4  registered drive to the arithmetic unit's iarg_A/iarg_B/iop.
REQ-007 i_alu_result  in  M; i_alu_status  in  4  arithmetic unit's o_result/o_status; status bit 3 = ERROR.
REQ-008 o_rsp_valid  out  1  response available; i_rsp_ready  in  1  response consumed when both high at an edge.
REQ-009 o_rsp_result  out  M; o_rsp_status  out  4; o_rsp_op  out  4  head response contents.
REQ-010 o_err_cnt  out  8  count of responses with ERROR set.

Function
REQ-011 SHALL act as the initiator for the arithmetic unit, which has one-cycle registered latency and shares clk/i_reset.
REQ-012 Pipeline: stage S1 valid bit set on command accept edge k (o_alu_* loaded at k); stage S2 valid at k+1 (ALU samples); capture into response FIFO at k+2.
REQ-013 Command-to-o_rsp_valid latency SHALL be exactly 2 cycles when FIFO is empty and i_rsp_ready high.
REQ-014 Throughput SHALL be one command per cycle when not back-pressured.
REQ-015 o_cmd_ready SHALL equal (fifo_count + S1_v + S2_v) < RSP_DEPTH, derived from registers only (no combinational path from i_rsp_ready).
REQ-016 Captured op SHALL travel with its stage; o_rsp_op equals the i_cmd_op of that command.
REQ-017 When captured i_alu_status[3]=1, stored result SHALL be forced to 0 (ALU drives undefined value); status stored unmodified.
REQ-018 When no command accepted, o_alu_* SHALL hold previous values; ALU output for non-valid stages SHALL be ignored.
REQ-019 FIFO: push at capture, pop on o_rsp_valid&&i_rsp_ready; simultaneous push/pop SHALL leave count unchanged; pointers wrap modulo RSP_DEPTH.
REQ-020 o_rsp_valid = (fifo_count != 0); o_rsp_* SHALL be stable while o_rsp_valid && !i_rsp_ready.
REQ-021 FIFO SHALL never overflow; REQ-015 guarantees a slot for every in-flight command.
REQ-022 Responses SHALL be delivered strictly in command order.

Reset
REQ-023 On i_reset low SHALL asynchronously clear: S1_v, S2_v, FIFO pointers/count, o_alu_A/B=0, o_alu_op=0, o_rsp_valid=0, o_rsp_result/status/op=0, o_err_cnt=0.
REQ-024 o_cmd_ready SHALL be 1 from the first edge after reset release.
REQ-025 Reset mid-operation SHALL discard in-flight and queued responses; no stale response after release.

Configuration
REQ-026 Macro ALU_DRV_ERRCNT_EN defined: o_err_cnt increments by 1 per FIFO push with status[3]=1, saturates at 255, never wraps.
REQ-027 Macro undefined: no counter logic; o_err_cnt tied to 0; all other behaviour identical.

Verification
REQ-028 op=0010, A=100, B=7 accepted at edge 0 -> o_rsp_valid after edge 2, result=14, status=0000, op=0010.
REQ-029 op=0010, B=0 -> result=0, status=1000; o_err_cnt=1 (macro on) / 0 (macro off); op=0101 -> status=1000, result=0.
REQ-030 op=0011, A=0x80000005 -> result=0xFFFFFFFB; op=0011, A=0x00000005 -> result=0x00000005.
REQ-031 i_rsp_ready=0, 4 back-to-back commands -> o_cmd_ready low after 4th accept; single pop -> ready high next cycle; order preserved.
REQ-032 Continuous streaming with i_rsp_ready=1, push and pop same cycle -> count constant, one response per cycle, no drops.
REQ-033 Assert i_reset with 2 in flight and 2 queued -> all outputs zero immediately; after release no response appears without new command.

Source files
------------

// File: rtl/alu_txn_driver.sv
// Initiator for a one-cycle-latency arithmetic unit: two-stage valid pipeline plus an in-order response FIFO.
// Optional macro ALU_DRV_ERRCNT_EN enables the saturating error counter on o_err_cnt.
module alu_txn_driver #(
    parameter int M         = 32,
    parameter int RSP_DEPTH = 4
) (
    input  logic         clk,
    input  logic         i_reset,
    input  logic         i_cmd_valid,
    output logic         o_cmd_ready,
    input  logic [M-1:0] i_cmd_A,
    input  logic [M-1:0] i_cmd_B,
    input  logic [3:0]   i_cmd_op,
    output logic [M-1:0] o_alu_A,
    output logic [M-1:0] o_alu_B,
    output logic [3:0]   o_alu_op,
    input  logic [M-1:0] i_alu_result,
    input  logic [3:0]   i_alu_status,
    output logic         o_rsp_valid,
    input  logic         i_rsp_ready,
    output logic [M-1:0] o_rsp_result,
    output logic [3:0]   o_rsp_status,
    output logic [3:0]   o_rsp_op,
    output logic [7:0]   o_err_cnt
);
    localparam int AW = $clog2(RSP_DEPTH);
    localparam int OW = AW + 2;

    typedef struct packed {
        logic [M-1:0] result;
        logic [3:0]   status;
        logic [3:0]   op;
    } rsp_t;

    // vld_pipe[1]: operands on o_alu_*; vld_pipe[2]: ALU result valid this cycle
    logic [2:1]    vld_pipe;
    logic [3:0]    s2_op;
    rsp_t          mem [RSP_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [OW-1:0] occupancy;
    logic          cmd_fire, push, pop;
    rsp_t          push_data, head;

    // Every in-flight command already owns a FIFO slot, so capture can never overflow.
    assign occupancy   = OW'(count) + OW'(vld_pipe[1]) + OW'(vld_pipe[2]);
    assign o_cmd_ready = occupancy < OW'(RSP_DEPTH);
    assign cmd_fire    = i_cmd_valid && o_cmd_ready;

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            vld_pipe <= '0;
            o_alu_A  <= '0;
            o_alu_B  <= '0;
            o_alu_op <= '0;
            s2_op    <= '0;
        end else begin
            vld_pipe <= {vld_pipe[1], cmd_fire};
            if (cmd_fire) begin
                o_alu_A  <= i_cmd_A;
                o_alu_B  <= i_cmd_B;
                o_alu_op <= i_cmd_op;
            end
            if (vld_pipe[1])
                s2_op <= o_alu_op;
        end
    end

    // ALU result is undefined on ERROR, so store zero instead.
    assign push             = vld_pipe[2];
    assign pop              = o_rsp_valid && i_rsp_ready;
    assign push_data.result = i_alu_status[3] ? '0 : i_alu_result;
    assign push_data.status = i_alu_status;
    assign push_data.op     = s2_op;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Mask the uninitialised/stale storage so outputs read zero whenever the FIFO is empty.
    assign head         = mem[rd_ptr];
    assign o_rsp_valid  = (count != '0);
    assign o_rsp_result = o_rsp_valid ? head.result : '0;
    assign o_rsp_status = o_rsp_valid ? head.status : '0;
    assign o_rsp_op     = o_rsp_valid ? head.op     : '0;

`ifdef ALU_DRV_ERRCNT_EN
    logic [7:0] err_cnt;

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset)
            err_cnt <= '0;
        else if (push && i_alu_status[3] && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 1'b1;
    end

    assign o_err_cnt = err_cnt;
`else
    assign o_err_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_txn_driver.sv
// Bench for alu_txn_driver: behavioural ALU model, scoreboard queue, vector table and corner-case sequences.
module tb_alu_txn_driver;
    logic        clk = 1'b0;
    logic        i_reset = 1'b0;
    logic        i_cmd_valid, o_cmd_ready;
    logic [31:0] i_cmd_A, i_cmd_B;
    logic [3:0]  i_cmd_op;
    logic [31:0] o_alu_A, o_alu_B;
    logic [3:0]  o_alu_op;
    logic [31:0] i_alu_result;
    logic [3:0]  i_alu_status;
    logic        o_rsp_valid, i_rsp_ready;
    logic [31:0] o_rsp_result;
    logic [3:0]  o_rsp_status, o_rsp_op;
    logic [7:0]  o_err_cnt;

    always #5 clk = ~clk;

    alu_txn_driver #(.M(32), .RSP_DEPTH(4)) dut (
        .clk(clk), .i_reset(i_reset),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_A(i_cmd_A), .i_cmd_B(i_cmd_B), .i_cmd_op(i_cmd_op),
        .o_alu_A(o_alu_A), .o_alu_B(o_alu_B), .o_alu_op(o_alu_op),
        .i_alu_result(i_alu_result), .i_alu_status(i_alu_status),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_result(o_rsp_result), .o_rsp_status(o_rsp_status), .o_rsp_op(o_rsp_op),
        .o_err_cnt(o_err_cnt)
    );

`ifdef ALU_DRV_ERRCNT_EN
    localparam bit ERRCNT = 1'b1;
`else
    localparam bit ERRCNT = 1'b0;
`endif

    typedef struct packed { logic [31:0] r; logic [3:0] s; } alu_out_t;
    typedef struct packed { logic [31:0] result; logic [3:0] status; logic [3:0] op; } exp_t;
    typedef struct { logic [3:0] op; logic [31:0] a; logic [31:0] b; logic [31:0] res; logic [3:0] st; } vec_t;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   exp_err = 0;
    exp_t sb[$];

    // ALU behaviour: 0 add, 1 sub, 2 unsigned div (B=0 -> ERROR), 3 sign-magnitude to two's complement, 5 ERROR, other xor
    function automatic alu_out_t alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        alu_out_t o;
        o.r = '0;
        o.s = '0;
        case (op)
            4'd0: o.r = a + b;
            4'd1: o.r = a - b;
            4'd2: if (b == 0) o.s = 4'b1000; else o.r = a / b;
            4'd3: o.r = a[31] ? (32'd0 - {1'b0, a[30:0]}) : a;
            4'd5: o.s = 4'b1000;
            default: o.r = a ^ b;
        endcase
        return o;
    endfunction

    // One-cycle registered ALU; on ERROR it drives garbage that the driver must zero.
    always @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            i_alu_result <= '0;
            i_alu_status <= '0;
        end else begin
            i_alu_result <= alu_fn(o_alu_op, o_alu_A, o_alu_B).s[3] ? 32'hDEADBEEF : alu_fn(o_alu_op, o_alu_A, o_alu_B).r;
            i_alu_status <= alu_fn(o_alu_op, o_alu_A, o_alu_B).s;
        end
    end

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Response monitor: handshake completes at the next rising edge.
    always @(negedge clk) begin
        exp_t e;
        if (i_reset && o_rsp_valid && i_rsp_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_rsp: got %0h expected none", {o_rsp_result, o_rsp_status, o_rsp_op});
            end else begin
                e = sb.pop_front();
                chk("rsp", {24'd0, o_rsp_result, o_rsp_status, o_rsp_op}, {24'd0, e});
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic [3:0] st);
        int w;
        i_cmd_valid = 1'b1;
        i_cmd_op    = op;
        i_cmd_A     = a;
        i_cmd_B     = b;
        w = 0;
        while (!o_cmd_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) begin
            tests++;
            fails++;
            $display("FAIL cmd_timeout: got ready=0 expected ready=1 within 50 cycles");
            i_cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        sb.push_back({res, st, op});
        if (st[3] && exp_err < 255) exp_err++;
        #1 i_cmd_valid = 1'b0;
    endtask

    task automatic send_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        alu_out_t o;
        o = alu_fn(op, a, b);
        send(op, a, b, o.r, o.s);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 100) begin
            @(posedge clk);
            w++;
        end
        #1;
        chk("drain_left", 64'(sb.size()), 64'd0);
    endtask

    vec_t vecs[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{4'd2, 32'd100,        32'd7,          32'd14,         4'b0000};
        vecs[1] = '{4'd2, 32'd5,          32'd0,          32'd0,          4'b1000};
        vecs[2] = '{4'd5, 32'd1,          32'd2,          32'd0,          4'b1000};
        vecs[3] = '{4'd3, 32'h80000005,   32'd0,          32'hFFFFFFFB,   4'b0000};
        vecs[4] = '{4'd3, 32'h00000005,   32'd0,          32'h00000005,   4'b0000};
        vecs[5] = '{4'd0, 32'hFFFFFFFF,   32'd1,          32'd0,          4'b0000};
        vecs[6] = '{4'd1, 32'd0,          32'd1,          32'hFFFFFFFF,   4'b0000};
        vecs[7] = '{4'd4, 32'hF0F0F0F0,   32'hFF00FF00,   32'h0FF00FF0,   4'b0000};

        i_cmd_valid = 1'b0;
        i_cmd_A = '0; i_cmd_B = '0; i_cmd_op = '0;
        i_rsp_ready = 1'b1;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
        chk("rst_alu_A", 64'(o_alu_A), 64'd0);
        chk("rst_alu_op", 64'(o_alu_op), 64'd0);
        chk("rst_rsp_result", 64'(o_rsp_result), 64'd0);
        chk("rst_err_cnt", 64'(o_err_cnt), 64'd0);
        @(negedge clk) i_reset = 1'b1;
        @(posedge clk);
        #1 chk("ready_after_reset", 64'(o_cmd_ready), 64'd1);

        // exact two-cycle latency
        i_cmd_valid = 1'b1; i_cmd_op = 4'd2; i_cmd_A = 32'd100; i_cmd_B = 32'd7;
        @(posedge clk);
        sb.push_back({32'd14, 4'b0000, 4'd2});
        #1 i_cmd_valid = 1'b0;
        chk("lat_edge0", 64'(o_rsp_valid), 64'd0);
        chk("lat_alu_A", 64'(o_alu_A), 64'd100);
        @(posedge clk);
        #1 chk("lat_edge1", 64'(o_rsp_valid), 64'd0);
        @(posedge clk);
        #1 chk("lat_edge2", 64'(o_rsp_valid), 64'd1);
        drain();

        // table vectors, back to back
        for (int i = 0; i < 8; i++)
            send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].st);
        drain();
        chk("err_cnt_table", 64'(o_err_cnt), ERRCNT ? 64'(exp_err) : 64'd0);

        // back-pressure: four commands fill the FIFO, one pop reopens it
        i_rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send(vecs[i + 4].op, vecs[i + 4].a, vecs[i + 4].b, vecs[i + 4].res, vecs[i + 4].st);
        chk("bp_ready_low", 64'(o_cmd_ready), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_ready_still_low", 64'(o_cmd_ready), 64'd0);
        chk("bp_head_stable0", {24'd0, o_rsp_result, o_rsp_status, o_rsp_op}, {24'd0, sb[0]});
        @(posedge clk);
        #1 chk("bp_head_stable1", {24'd0, o_rsp_result, o_rsp_status, o_rsp_op}, {24'd0, sb[0]});
        i_rsp_ready = 1'b1;
        @(posedge clk);
        #1 i_rsp_ready = 1'b0;
        chk("bp_ready_after_pop", 64'(o_cmd_ready), 64'd1);
        chk("bp_sb_left", 64'(sb.size()), 64'd3);
        i_rsp_ready = 1'b1;
        drain();

        // streaming at full rate
        begin
            int t0;
            t0 = cyc;
            for (int i = 0; i < 40; i++)
                send_model(4'($urandom_range(0, 5)), $urandom,
                           ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom);
            chk("stream_cycles", 64'(cyc - t0), 64'd40);
        end
        drain();

        // error counter saturation
        for (int i = 0; i < 260; i++)
            send(4'd5, 32'(i), 32'd0, 32'd0, 4'b1000);
        drain();
        chk("err_cnt_sat", 64'(o_err_cnt), ERRCNT ? 64'd255 : 64'd0);

        // reset with two in flight and two queued
        i_rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++)
            send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].st);
        i_reset = 1'b0;
        #1;
        sb.delete();
        exp_err = 0;
        chk("mid_rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
        chk("mid_rst_alu", {o_alu_A, o_alu_B}, 64'd0);
        chk("mid_rst_alu_op", 64'(o_alu_op), 64'd0);
        chk("mid_rst_rsp", {24'd0, o_rsp_result, o_rsp_status, o_rsp_op}, 64'd0);
        chk("mid_rst_err_cnt", 64'(o_err_cnt), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        i_reset = 1'b1;
        i_rsp_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1 chk("no_stale_rsp", 64'(o_rsp_valid), 64'd0);
        send(vecs[0].op, vecs[0].a, vecs[0].b, vecs[0].res, vecs[0].st);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
